crc8_frame_checker: RTL and testbench

Receive-side counterpart of the CRC-8/8b10b transmit path. Consumes decoded symbols (8-bit data plus K flag) from the 8b10b decoder, delineates frames on K-character delimiters, and recomputes CRC-8 (poly 0x07) over the payload. Presents the payload with a valid or CRC-error pulse, and maintains a frame-lock indication for trigger logic downstream.

---
 rtl/crc8_frame_checker_pkg.sv | 29 ++
 rtl/crc8_frame_checker_crc8_byte_update.sv | 14 +
 rtl/crc8_frame_checker.sv | 174 +++++++++++++++++
 tb/tb_crc8_frame_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/crc8_frame_checker_pkg.sv
// Shared definitions for the CRC-8 framed link: FSM states, delimiter
// K-characters and the byte-wide CRC-8 step used on both link ends.
package crc8_frame_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_CRC,
        ST_EOF
    } frame_state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_1 = 8'h3C;

    // MSB-first, non-reflected, no final XOR.
    function automatic logic [7:0] crc8_next(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_frame_checker_crc8_byte_update.sv
// Combinational next-CRC for one byte.
module crc8_byte_update
    import crc8_frame_checker_pkg::*;
#(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] next_crc
);

    assign next_crc = crc8_next(crc, data, POLY);

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side frame delineation, CRC-8 check and frame-lock tracking on
// decoded 8b10b symbols.
module crc8_frame_checker
    import crc8_frame_checker_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL    = 8'h07,
    parameter logic [7:0] CRC_INIT      = 8'h00,
    parameter int         PAYLOAD_BYTES = 7,
    parameter logic [7:0] SOF_CHAR      = K28_5,
    parameter logic [7:0] EOF_CHAR      = K28_1,
    parameter int         LOCK_FRAMES   = 2,
    parameter int         UNLOCK_FRAMES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_valid_i,
    input  logic [7:0]                 data_i,
    input  logic                       k_i,
    input  logic                       code_err_i,
    output logic [8*PAYLOAD_BYTES-1:0] payload_o,
    output logic                       frame_valid_o,
    output logic                       crc_err_o,
    output logic                       frame_err_o,
    output logic                       sync_o
);

    localparam int CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam int UW = $clog2(UNLOCK_FRAMES + 1);

    frame_state_t               state_reg;
    logic [7:0]                 crc_reg;
    logic [7:0]                 crc_next;
    logic [CW-1:0]              cnt_reg;
    logic                       match_reg;
    logic [LW-1:0]              good_cnt_reg;
    logic [UW-1:0]              bad_cnt_reg;
    logic                       sync_reg;
    logic                       frame_valid_reg;
    logic                       crc_err_reg;
    logic                       frame_err_reg;
    logic [8*PAYLOAD_BYTES-1:0] payload_reg;
    logic [8*PAYLOAD_BYTES-1:0] shadow_flat;
    logic [7:0]                 shadow_mem [PAYLOAD_BYTES];

    logic is_sof;
    logic shadow_we;
    logic good_evt;
    logic crc_evt;
    logic abort_evt;

    crc8_byte_update #(
        .POLY(POLYNOMIAL)
    ) u_crc (
        .crc     (crc_reg),
        .data    (data_i),
        .next_crc(crc_next)
    );

    // A corrupted symbol is never trusted as a frame opener.
    assign is_sof    = sym_valid_i && k_i && (data_i == SOF_CHAR) && !code_err_i;
    assign shadow_we = sym_valid_i && (state_reg == ST_PAYLOAD) && !k_i && !code_err_i;

    always_comb begin
        good_evt  = 1'b0;
        crc_evt   = 1'b0;
        abort_evt = 1'b0;
        if (sym_valid_i && (state_reg != ST_HUNT)) begin
            if (code_err_i) begin
                abort_evt = 1'b1;
            end else begin
                case (state_reg)
                    ST_PAYLOAD, ST_CRC: abort_evt = k_i;
                    ST_EOF: begin
                        if (k_i && (data_i == EOF_CHAR)) begin
                            good_evt = match_reg;
                            crc_evt  = !match_reg;
                        end else begin
                            abort_evt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_mem[cnt_reg] <= data_i;
        end
    end

    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_pack
        assign shadow_flat[8*(PAYLOAD_BYTES-1-gi) +: 8] = shadow_mem[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_HUNT;
            crc_reg         <= CRC_INIT;
            cnt_reg         <= '0;
            match_reg       <= 1'b0;
            good_cnt_reg    <= '0;
            bad_cnt_reg     <= '0;
            sync_reg        <= 1'b0;
            frame_valid_reg <= 1'b0;
            crc_err_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            payload_reg     <= '0;
        end else begin
            frame_valid_reg <= good_evt;
            crc_err_reg     <= crc_evt;
            frame_err_reg   <= abort_evt;

            if (good_evt) begin
                payload_reg <= shadow_flat;
            end

            if (sym_valid_i) begin
                if (is_sof) begin
                    state_reg <= ST_PAYLOAD;
                    crc_reg   <= CRC_INIT;
                    cnt_reg   <= '0;
                end else if (abort_evt) begin
                    state_reg <= ST_HUNT;
                end else begin
                    case (state_reg)
                        ST_HUNT: ;
                        ST_PAYLOAD: begin
                            crc_reg <= crc_next;
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg == CW'(PAYLOAD_BYTES - 1)) begin
                                state_reg <= ST_CRC;
                            end
                        end
                        ST_CRC: begin
                            match_reg <= (data_i == crc_reg);
                            state_reg <= ST_EOF;
                        end
                        ST_EOF:  state_reg <= ST_HUNT;
                        default: state_reg <= ST_HUNT;
                    endcase
                end
            end

            // Lock follows the same symbol that decides the pulse.
            if (good_evt) begin
                bad_cnt_reg <= '0;
                if (good_cnt_reg != LW'(LOCK_FRAMES)) begin
                    good_cnt_reg <= good_cnt_reg + 1'b1;
                end
                if (good_cnt_reg >= LW'(LOCK_FRAMES - 1)) begin
                    sync_reg <= 1'b1;
                end
            end else if (crc_evt || abort_evt) begin
                good_cnt_reg <= '0;
                if (bad_cnt_reg != UW'(UNLOCK_FRAMES)) begin
                    bad_cnt_reg <= bad_cnt_reg + 1'b1;
                end
                if (bad_cnt_reg >= UW'(UNLOCK_FRAMES - 1)) begin
                    sync_reg <= 1'b0;
                end
            end
        end
    end

    assign payload_o     = payload_reg;
    assign frame_valid_o = frame_valid_reg;
    assign crc_err_o     = crc_err_reg;
    assign frame_err_o   = frame_err_reg;
    assign sync_o        = sync_reg;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: default 7-byte instance plus a
// 9-byte instance for the "123456789" check value.
module tb_crc8_frame_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v7 = 1'b0;
    logic        v9 = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        k = 1'b0;
    logic        err = 1'b0;

    logic [55:0] pl7;
    logic        fv7, ce7, fe7, sy7;
    logic [71:0] pl9;
    logic        fv9, ce9, fe9, sy9;

    int n_checks = 0;
    int n_fail   = 0;

    bit sel9 = 1'b0;
    int acc_fv, acc_ce, acc_fe;
    logic last_fv, last_ce, last_sync;

    always #5 clk = ~clk;

    crc8_frame_checker dut7 (
        .clk(clk), .reset(reset), .sym_valid_i(v7), .data_i(data), .k_i(k),
        .code_err_i(err), .payload_o(pl7), .frame_valid_o(fv7),
        .crc_err_o(ce7), .frame_err_o(fe7), .sync_o(sy7)
    );

    crc8_frame_checker #(.PAYLOAD_BYTES(9)) dut9 (
        .clk(clk), .reset(reset), .sym_valid_i(v9), .data_i(data), .k_i(k),
        .code_err_i(err), .payload_o(pl9), .frame_valid_o(fv9),
        .crc_err_o(ce9), .frame_err_o(fe9), .sync_o(sy9)
    );

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        acc_fv = 0;
        acc_ce = 0;
        acc_fe = 0;
    endtask

    task automatic capture();
        if (sel9) begin
            acc_fv += int'(fv9); acc_ce += int'(ce9); acc_fe += int'(fe9);
            last_fv = fv9; last_ce = ce9; last_sync = sy9;
        end else begin
            acc_fv += int'(fv7); acc_ce += int'(ce7); acc_fe += int'(fe7);
            last_fv = fv7; last_ce = ce7; last_sync = sy7;
        end
    endtask

    // One symbol per call; optional idle cycle afterwards.
    task automatic sym(input logic [7:0] d, input logic kk, input logic e, input bit gap);
        data = d;
        k    = kk;
        err  = e;
        if (sel9) v9 = 1'b1; else v7 = 1'b1;
        @(posedge clk);
        #1;
        v7 = 1'b0;
        v9 = 1'b0;
        capture();
        if (gap) begin
            @(posedge clk);
            #1;
            capture();
        end
    endtask

    task automatic send_frame(input logic [71:0] pl, input int nbytes, input logic [7:0] crc,
                              input int err_pos, input bit gap);
        sym(8'hBC, 1'b1, 1'b0, gap);
        for (int i = 0; i < nbytes; i++) begin
            sym(pl[8*(nbytes-1-i) +: 8], 1'b0, (i == err_pos), gap);
        end
        sym(crc, 1'b0, 1'b0, gap);
        sym(8'h3C, 1'b1, 1'b0, gap);
        $display("frame pl=%0h crc=%0h errpos=%0d gap=%0d -> fv=%0d ce=%0d fe=%0d sync=%0d",
                 pl, crc, err_pos, gap, acc_fv, acc_ce, acc_fe, last_sync);
    endtask

    task automatic check_counts(input string tag, input int efv, input int ece, input int efe);
        check_eq({tag, "_fv"}, 72'(acc_fv), 72'(efv));
        check_eq({tag, "_ce"}, 72'(acc_ce), 72'(ece));
        check_eq({tag, "_fe"}, 72'(acc_fe), 72'(efe));
    endtask

    localparam logic [55:0] PL_A = 56'h00000000000001;
    localparam logic [55:0] PL_B = 56'h00000000000100;
    localparam logic [55:0] PL_C = 56'h00000000000002;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_payload", 72'(pl7), 72'h0);
        check_eq("rst_pulses", {fv7, ce7, fe7}, 3'b000);
        check_eq("rst_sync", sy7, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Garbage in HUNT never raises an error.
        clear_acc();
        sym(8'h55, 1'b0, 1'b0, 1'b0);
        sym(8'h3C, 1'b1, 1'b0, 1'b0);
        sym(8'hF7, 1'b1, 1'b0, 1'b0);
        sym(8'hBC, 1'b0, 1'b0, 1'b0);
        sym(8'h12, 1'b0, 1'b1, 1'b0);
        $display("garbage -> fe=%0d ce=%0d fv=%0d", acc_fe, acc_ce, acc_fv);
        check_counts("garbage", 0, 0, 0);

        clear_acc();
        send_frame(72'h0, 7, 8'h00, -1, 1'b0);
        check_counts("zeros", 1, 0, 0);
        check_eq("zeros_fv_timing", last_fv, 1'b1);
        check_eq("zeros_payload", 72'(pl7), 72'h0);
        check_eq("zeros_sync", last_sync, 1'b0);

        clear_acc();
        send_frame(72'(PL_A), 7, 8'h07, -1, 1'b0);
        check_counts("frameA", 1, 0, 0);
        check_eq("frameA_payload", 72'(pl7), 72'(PL_A));
        check_eq("frameA_sync_rise", last_sync, 1'b1);

        for (int f = 0; f < 3; f++) begin
            clear_acc();
            send_frame(72'h0, 7, 8'h00, 2, 1'b0);
            check_counts($sformatf("codeerr%0d", f), 0, 0, 1);
            check_eq($sformatf("codeerr%0d_sync", f), last_sync, (f < 2));
        end
        check_eq("codeerr_payload_kept", 72'(pl7), 72'(PL_A));

        clear_acc();
        send_frame(72'(PL_B), 7, 8'h16, -1, 1'b0);
        check_counts("crcbad", 0, 1, 0);
        check_eq("crcbad_timing", last_ce, 1'b1);
        check_eq("crcbad_payload", 72'(pl7), 72'(PL_A));

        // Frame cut short by a fresh SOF; the new frame must still land.
        clear_acc();
        sym(8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sym(8'hAA, 1'b0, 1'b0, 1'b0);
        send_frame(72'(PL_B), 7, 8'h15, -1, 1'b0);
        check_counts("resof", 1, 0, 1);
        check_eq("resof_payload", 72'(pl7), 72'(PL_B));

        clear_acc();
        send_frame(72'(PL_C), 7, 8'h0E, -1, 1'b1);
        check_counts("gapped", 1, 0, 0);
        check_eq("gapped_payload", 72'(pl7), 72'(PL_C));

        // EOF slot holding a data byte aborts the frame.
        clear_acc();
        sym(8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) sym(8'h00, 1'b0, 1'b0, 1'b0);
        sym(8'h00, 1'b0, 1'b0, 1'b0);
        sym(8'h3C, 1'b0, 1'b0, 1'b0);
        $display("bad_eof -> fe=%0d fv=%0d", acc_fe, acc_fv);
        check_counts("bad_eof", 0, 0, 1);
        check_eq("bad_eof_payload", 72'(pl7), 72'(PL_C));

        // Asynchronous reset in the middle of the payload.
        clear_acc();
        sym(8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sym(8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_payload", 72'(pl7), 72'h0);
        check_eq("midrst_flags", {fv7, ce7, fe7, sy7}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) sym(8'h00, 1'b0, 1'b0, 1'b0);
        sym(8'h01, 1'b0, 1'b0, 1'b0);
        sym(8'h07, 1'b0, 1'b0, 1'b0);
        sym(8'h3C, 1'b1, 1'b0, 1'b0);
        $display("midrst tail -> fv=%0d ce=%0d fe=%0d", acc_fv, acc_ce, acc_fe);
        check_counts("midrst_tail", 0, 0, 0);
        clear_acc();
        send_frame(72'(PL_A), 7, 8'h07, -1, 1'b0);
        check_counts("post_rst", 1, 0, 0);
        check_eq("post_rst_payload", 72'(pl7), 72'(PL_A));

        sel9 = 1'b1;
        clear_acc();
        send_frame(72'h313233343536373839, 9, 8'hF4, -1, 1'b0);
        check_counts("ascii9", 1, 0, 0);
        check_eq("ascii9_payload", pl9, 72'h313233343536373839);
        clear_acc();
        send_frame(72'h313233343536373839, 9, 8'hF5, -1, 1'b0);
        check_counts("ascii9_bad", 0, 1, 0);
        check_eq("ascii9_bad_payload", pl9, 72'h313233343536373839);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
